blocpu_serial_loader: RTL and testbench

//  Byte-stream command parser that drives the blocpu_core instruction-load port and run/reset controls.

---
 rtl/blocpu_serial_loader.sv | 141 ++++++++++++++
 tb/tb_blocpu_serial_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blocpu_serial_loader.sv
// blocpu_serial_loader: UART byte-stream command parser driving the blocpu_core load port and run/reset controls.
module blocpu_serial_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [11:0] instr_data,
  output logic [15:0] instr_addr,
  output logic        instr_write,
  output logic        core_run,
  output logic        core_reset,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, COUNT, DATA_HI, DATA_LO, CSUM, REPLY} state_t;
  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] NAK = 8'h45;
  state_t state, state_n;
  logic [15:0] addr, addr_n, instr_addr_n;
  logic [8:0] cnt, cnt_n;
  logic [7:0] hi, hi_n, sum, sum_n, reply, reply_n, tx_data_n;
  logic [11:0] instr_data_n;
  logic [31:0] tmo, tmo_n;
  logic err, err_n, tx_start_n, instr_write_n, core_run_n, core_reset_n;
  logic in_frame, expired;
  assign in_frame = state != IDLE && state != REPLY;
  assign expired = TIMEOUT_CYCLES != 0 && !rx_ready && tmo + 32'd1 == TIMEOUT_CYCLES;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      hi <= '0;
      sum <= '0;
      reply <= '0;
      tmo <= '0;
      err <= 1'b0;
      tx_data <= '0;
      tx_start <= 1'b0;
      instr_data <= '0;
      instr_addr <= '0;
      instr_write <= 1'b0;
      core_run <= 1'b0;
      core_reset <= 1'b0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      cnt <= cnt_n;
      hi <= hi_n;
      sum <= sum_n;
      reply <= reply_n;
      tmo <= tmo_n;
      err <= err_n;
      tx_data <= tx_data_n;
      tx_start <= tx_start_n;
      instr_data <= instr_data_n;
      instr_addr <= instr_addr_n;
      instr_write <= instr_write_n;
      core_run <= core_run_n;
      core_reset <= core_reset_n;
    end
  end
  always_comb begin
    state_n = state;
    addr_n = addr;
    cnt_n = cnt;
    hi_n = hi;
    sum_n = (rx_ready && in_frame) ? sum + rx_data : sum;
    reply_n = reply;
    tmo_n = in_frame ? (rx_ready ? 32'd0 : tmo + 32'd1) : 32'd0;
    err_n = err;
    tx_data_n = tx_data;
    tx_start_n = 1'b0;
    instr_data_n = instr_data;
    instr_addr_n = instr_addr;
    instr_write_n = 1'b0;
    core_run_n = core_run;
    core_reset_n = 1'b0;
    case (state)
      IDLE: if (rx_ready) begin
        if (rx_data == 8'h4C) begin
          core_run_n = 1'b0;
          err_n = 1'b0;
          sum_n = 8'h4C;
          state_n = ADDR_HI;
        end else if (rx_data == 8'h52 || rx_data == 8'h53 || rx_data == 8'h58) begin
          core_run_n = rx_data == 8'h52;
          core_reset_n = rx_data == 8'h58;
          reply_n = ACK;
          state_n = REPLY;
        end
      end
      ADDR_HI: if (rx_ready) begin
        addr_n[15:8] = rx_data;
        state_n = ADDR_LO;
      end
      ADDR_LO: if (rx_ready) begin
        addr_n[7:0] = rx_data;
        state_n = COUNT;
      end
      COUNT: if (rx_ready) begin
        cnt_n = {rx_data == 8'd0, rx_data};
        state_n = DATA_HI;
      end
      DATA_HI: if (rx_ready) begin
        hi_n = rx_data;
        state_n = DATA_LO;
      end
      DATA_LO: if (rx_ready) begin
        // A bad high nibble skips the write but keeps the address stream aligned
        if (hi[7:4] == 4'd0) begin
          instr_data_n = {hi[3:0], rx_data};
          instr_addr_n = addr;
          instr_write_n = 1'b1;
        end else err_n = 1'b1;
        addr_n = addr + 16'd1;
        cnt_n = cnt - 9'd1;
        state_n = cnt == 9'd1 ? CSUM : DATA_HI;
      end
      CSUM: if (rx_ready) begin
        reply_n = (sum_n != 8'd0 || err) ? NAK : ACK;
        state_n = REPLY;
      end
      REPLY: if (!tx_busy) begin
        tx_data_n = reply;
        tx_start_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (in_frame && expired) begin
      reply_n = NAK;
      state_n = REPLY;
    end
  end
endmodule

// File: tb/tb_blocpu_serial_loader.sv
// tb_blocpu_serial_loader: directed scenario tests for the serial loader with hand-computed frames and replies.
module tb_blocpu_serial_loader;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, reset = 1'b1, rx_ready = 1'b0, tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data;
  logic tx_start, instr_write, core_run, core_reset, busy;
  logic [11:0] instr_data;
  logic [15:0] instr_addr;
  int checks = 0, errors = 0, wr_dbl = 0, crst = 0;
  logic prev_w = 1'b0;
  logic [15:0] wa[$];
  logic [11:0] wd[$];
  logic [7:0] tx_q[$];
  bq_t fr;
  logic [7:0] rb;
  bit ok;

  blocpu_serial_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .instr_data(instr_data), .instr_addr(instr_addr), .instr_write(instr_write),
    .core_run(core_run), .core_reset(core_reset), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (instr_write) begin
      wa.push_back(instr_addr);
      wd.push_back(instr_data);
      if (prev_w) wr_dbl++;
    end
    prev_w = instr_write;
    if (tx_start) tx_q.push_back(tx_data);
    if (core_reset) crst++;
  end

  task automatic send_bytes(input bq_t q);
    foreach (q[i]) begin
      @(negedge clk);
      rx_data = q[i];
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    tx_q.delete();
    wr_dbl = 0;
    crst = 0;
  endtask

  task automatic wait_reply(output logic [7:0] b, output bit found);
    found = 0;
    b = 8'h00;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      if (tx_q.size() != 0) begin
        b = tx_q.pop_front();
        found = 1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_data, tx_start, instr_data, instr_addr, instr_write, core_run, core_reset, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {tx_data, tx_start, instr_data, instr_addr, instr_write, core_run, core_reset, busy});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load(input logic [7:0] csum, input logic [7:0] exp_reply, input string nm);
    clear_log();
    fr = '{8'h4C, 8'h00, 8'h10, 8'h02, 8'h01, 8'h23, 8'h04, 8'h56};
    fr.push_back(csum);
    send_bytes(fr);
    wait_reply(rb, ok);
    checks++;
    if (!ok || rb !== exp_reply) begin
      errors++;
      $display("FAIL %s_reply: got %h (seen %0d) required %h", nm, rb, ok, exp_reply);
    end
    checks++;
    if (wa.size() != 2) begin
      errors++;
      $display("FAIL %s_write_count: got %0d required 2", nm, wa.size());
    end else begin
      checks++;
      if ({wa[0], wd[0], wa[1], wd[1]} !== {16'h0010, 12'h123, 16'h0011, 12'h456}) begin
        errors++;
        $display("FAIL %s_writes: got %h/%h %h/%h required 0010/123 0011/456", nm, wa[0], wd[0], wa[1], wd[1]);
      end
    end
    checks++;
    if (wr_dbl != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse_busy: got wide_writes=%0d busy=%b required 0 0", nm, wr_dbl, busy);
    end
  endtask

  task automatic test_run_ctrl();
    clear_log();
    fr = '{8'h52};
    send_bytes(fr);
    wait_reply(rb, ok);
    checks++;
    if (!ok || rb !== 8'h4B || core_run !== 1'b1) begin
      errors++;
      $display("FAIL run_cmd: got reply=%h seen=%0d run=%b required 4b 1 1", rb, ok, core_run);
    end
    fr = '{8'h4C};
    send_bytes(fr);
    checks++;
    if (core_run !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_stops_run: got run=%b busy=%b required 0 1", core_run, busy);
    end
    wait_reply(rb, ok);
    checks++;
    if (!ok || rb !== 8'h45) begin
      errors++;
      $display("FAIL abandoned_frame_reply: got %h seen=%0d required 45", rb, ok);
    end
    fr = '{8'h52};
    send_bytes(fr);
    wait_reply(rb, ok);
    fr = '{8'h58};
    send_bytes(fr);
    wait_reply(rb, ok);
    checks++;
    if (!ok || rb !== 8'h4B || crst != 1 || core_run !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd: got reply=%h seen=%0d reset_clks=%0d run=%b required 4b 1 1 0", rb, ok, crst, core_run);
    end
    fr = '{8'h52};
    send_bytes(fr);
    wait_reply(rb, ok);
    fr = '{8'h53};
    send_bytes(fr);
    wait_reply(rb, ok);
    checks++;
    if (!ok || rb !== 8'h4B || core_run !== 1'b0) begin
      errors++;
      $display("FAIL stop_cmd: got reply=%h seen=%0d run=%b required 4b 1 0", rb, ok, core_run);
    end
    clear_log();
    fr = '{8'h41, 8'h00};
    send_bytes(fr);
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL unknown_byte: got busy=%b replies=%0d required 0 0", busy, tx_q.size());
    end
  endtask

  task automatic test_addr_wrap();
    clear_log();
    fr = '{8'h4C, 8'hFF, 8'hFF, 8'h02, 8'h01, 8'h23, 8'h04, 8'h56, 8'h36};
    send_bytes(fr);
    wait_reply(rb, ok);
    checks++;
    if (!ok || rb !== 8'h4B || wa.size() != 2) begin
      errors++;
      $display("FAIL wrap_frame: got reply=%h seen=%0d writes=%0d required 4b 1 2", rb, ok, wa.size());
    end else begin
      checks++;
      if ({wa[0], wd[0], wa[1], wd[1]} !== {16'hFFFF, 12'h123, 16'h0000, 12'h456}) begin
        errors++;
        $display("FAIL wrap_writes: got %h/%h %h/%h required ffff/123 0000/456", wa[0], wd[0], wa[1], wd[1]);
      end
    end
    clear_log();
    fr = '{8'h4C, 8'hFF, 8'hFF, 8'h02, 8'h01, 8'h23, 8'h10, 8'h56, 8'h2A};
    send_bytes(fr);
    wait_reply(rb, ok);
    checks++;
    if (!ok || rb !== 8'h45 || wa.size() != 1) begin
      errors++;
      $display("FAIL bad_hi_nibble: got reply=%h seen=%0d writes=%0d required 45 1 1", rb, ok, wa.size());
    end
    checks++;
    if (instr_addr !== 16'hFFFF || instr_data !== 12'h123) begin
      errors++;
      $display("FAIL bad_hi_hold: got %h/%h required ffff/123", instr_addr, instr_data);
    end
  endtask

  task automatic test_count_zero();
    clear_log();
    fr = '{8'h4C, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 256; i++) begin
      fr.push_back(8'h00);
      fr.push_back(8'(i));
    end
    fr.push_back(8'h34);
    send_bytes(fr);
    wait_reply(rb, ok);
    checks++;
    if (!ok || rb !== 8'h4B || wa.size() != 256) begin
      errors++;
      $display("FAIL count_zero: got reply=%h seen=%0d writes=%0d required 4b 1 256", rb, ok, wa.size());
    end else begin
      checks++;
      if (wa[255] !== 16'h00FF || wd[255] !== 12'h0FF || wa[0] !== 16'h0000) begin
        errors++;
        $display("FAIL count_zero_last: got %h/%h first %h required 00ff/0ff first 0000", wa[255], wd[255], wa[0]);
      end
    end
  endtask

  task automatic test_timeout();
    int k;
    clear_log();
    fr = '{8'h4C, 8'h00};
    send_bytes(fr);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clk);
      if (tx_start) k = i;
    end
    checks++;
    if (k != 17 || tx_data !== 8'h45) begin
      errors++;
      $display("FAIL timeout_reply: got at clk %0d data %h required at clk 17 data 45", k, tx_data);
    end
    checks++;
    if (busy !== 1'b0 || wa.size() != 0) begin
      errors++;
      $display("FAIL timeout_idle: got busy=%b writes=%0d required 0 0", busy, wa.size());
    end
  endtask

  task automatic test_tx_busy();
    int early;
    clear_log();
    @(negedge clk);
    tx_busy = 1'b1;
    fr = '{8'h52};
    send_bytes(fr);
    early = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_start) early++;
    end
    tx_busy = 1'b0;
    checks++;
    if (early != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tx_busy_hold: got early_starts=%0d busy=%b required 0 1", early, busy);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h4B) begin
      errors++;
      $display("FAIL tx_busy_release: got start=%b data=%h required 1 4b", tx_start, tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h4B) begin
      errors++;
      $display("FAIL tx_start_width: got start=%b data=%h required 0 4b", tx_start, tx_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    fr = '{8'h4C, 8'h00, 8'h20, 8'h01, 8'h05};
    send_bytes(fr);
    clear_log();
    @(negedge clk);
    rx_data = 8'h67;
    rx_ready = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if ({tx_data, tx_start, instr_data, instr_addr, instr_write, core_run, core_reset, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0", {tx_data, tx_start, instr_data, instr_addr, instr_write, core_run, core_reset, busy});
    end
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (wa.size() != 0 || busy !== 1'b0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL reset_abort: got writes=%0d busy=%b replies=%0d required 0 0 0", wa.size(), busy, tx_q.size());
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load(8'h24, 8'h4B, "load_good");
    test_load(8'h25, 8'h45, "load_bad_csum");
    test_run_ctrl();
    test_addr_wrap();
    test_count_zero();
    test_timeout();
    test_tx_busy();
    test_reset_mid_frame();
    test_load(8'h24, 8'h4B, "load_after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
